led_heartbeat_gen: RTL
======================

# led_heartbeat_gen

Parametrised multi-channel LED/PMOD status generator for the PL fabric. Replaces the ad-hoc per-clock free-running heartbeat counters with one block on a single fabric clock. Each channel drives one indicator in one of five modes: off, on, synchronous blink, repeating blink-code, or free-run counter MSB. All channels share one millisecond prescaler and one phase timer, so blinking indicators stay in lock-step.

## Interface
Parameters:
- NUM_CH, 4: number of indicator channels (1..16).
- CNT_W, 24: width of each channel's free-run counter.
- TICK_DIV, 125000: clk cycles per tick (1 ms at 125 MHz); legal range ≥2.
- HP_W, 16: width of the half-period input.

Ports:
- clk  in  1  fabric clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode_i  in  3*NUM_CH  per-channel mode; channel k is bits [3k+2:3k].
- code_i  in  4*NUM_CH  per-channel blink count for mode 3; channel k is bits [4k+3:4k].
- half_period_i  in  HP_W  blink half-period in ticks; 0 is treated as 1.
- led_o  out  NUM_CH  registered indicator outputs.
- phase_o  out  1  one-cycle strobe at every phase boundary.

## Operation
- Prescaler:
  - pre_cnt counts 0..TICK_DIV-1, then wraps to 0.
  - tick is high for the one cycle where pre_cnt == TICK_DIV-1.
- Phase timer:
  - On each tick, ph_cnt increments.
  - When ph_cnt == hp-1 on a tick, ph_cnt wraps to 0 and phase (internal) is high that cycle. hp = max(half_period_i, 1).
  - half_period_i is compared live; if it is lowered below the current ph_cnt, ph_cnt continues counting and wraps at the HP_W overflow. The same applies to any ph_cnt ≥ hp-1 when it is not hit exactly on a tick.
  - phase_o is phase registered (1 cycle late).
- Mode capture: mode_r[k] is mode_i registered. mode_chg[k] = (mode_i[k] != mode_r[k]).
- On the cycle mode_chg[k] is high, channel k's sub-state is re-initialised:
  - blink toggle = 0
  - FSM = GAP, gap_cnt = 0, blink_cnt = 0
  - free-run counter = 0
- Per-channel modes (value of mode_r):
  - 0: led = 0.
  - 1: led = 1.
  - 2 (blink): toggle flips on every phase; led = toggle.
  - 3 (code): FSM, described below.
  - 4 (free-run): counter increments every clk, wrapping mod 2^CNT_W; led = counter[CNT_W-1].
  - 5..7: treated as 0.
- Code FSM (advances only on phase; holds otherwise):
  - GAP, led 0: gap_cnt increments on each phase. On the phase where gap_cnt == 3, code_i[k] is latched into code_l.
    - code ≠ 0: go to ON with blink_cnt = 1.
    - code == 0: stay in GAP with gap_cnt = 0.
  - ON, led 1: next phase → OFF.
  - OFF, led 0: next phase:
    - blink_cnt == code_l: go to GAP with gap_cnt = 0.
    - otherwise: go to ON with blink_cnt + 1.
  - Changes to code_i mid-sequence take effect only at the next GAP exit.
- Simultaneous mode_chg and phase on a channel: the re-initialisation wins and that phase is ignored by the channel.

## Timing
- Reset values:
  - led_o = 0, phase_o = 0, mode_r = 0.
  - pre_cnt = 0, ph_cnt = 0.
  - All toggles 0, all FSMs GAP, all gap/blink counters 0, all free-run counters 0.
- First tick occurs TICK_DIV cycles after reset deasserts, i.e. at pre_cnt == TICK_DIV-1.
- Phase period is exactly TICK_DIV*hp cycles with a constant hp.
- Latency:
  - mode_i change → led_o reflects the new static mode (0/1) 2 cycles later. mode_i is registered into mode_r, then led_o is registered.
  - phase → blink/code led_o edge: 1 cycle. This edge is coincident with phase_o.
- Code sequence period for code N: (2N+4) phases. This is 4 gap phases, then N on/off pairs.
- Reset asserted mid-sequence: all state clears immediately (asynchronous). The sequence restarts from GAP after release.

## Test plan
- Use TICK_DIV=4 and half_period_i=2 unless noted, giving a phase every 8 cycles.
- Reset release, all modes 0 → led_o = 0. The first phase_o pulse is 9 cycles after release and repeats every 8 cycles.
- Ch0 mode 2 → led_o[0] toggles on each phase_o cycle with a 16-cycle period. Setting ch1 to mode 2 later → ch1 toggles in step with ch0 from its first phase after the change, starting low.
- Ch2 mode 3, code 3 → 4 phases low, then high/low ×3, repeat every 10 phases (80 cycles). Changing code to 1 mid-burst → the current burst completes 3 blinks, the next burst has 1.
- Ch3 mode 4, CNT_W=4 → led_o[3] = 0 for 8 cycles, then 1 for 8 cycles, repeating. Mode change to 1 → led_o[3] = 1 two cycles after the mode_i edge.
- half_period_i=0 → phase every 4 cycles, identical to half_period_i=1. Assert reset mid code burst → all led_o = 0 immediately, and phase_o resumes 9 cycles after release.

Source files
------------

// File: rtl/led_heartbeat_gen_if.sv
// Control/status bundle for led_heartbeat_gen: per-channel mode and blink code in,
// indicator outputs and the phase strobe back out.
interface led_heartbeat_gen_if #(
    parameter int NUM_CH = 4,
    parameter int HP_W   = 16
);
    logic [3*NUM_CH-1:0] mode_i;
    logic [4*NUM_CH-1:0] code_i;
    logic [HP_W-1:0]     half_period_i;
    logic [NUM_CH-1:0]   led_o;
    logic                phase_o;

    modport master (
        output mode_i,
        output code_i,
        output half_period_i,
        input  led_o,
        input  phase_o
    );

    modport slave (
        input  mode_i,
        input  code_i,
        input  half_period_i,
        output led_o,
        output phase_o
    );
endinterface

// File: rtl/led_heartbeat_gen.sv
// Multi-channel LED/PMOD status generator. One tick prescaler and one phase timer
// are shared by every channel so blinking indicators stay in lock-step.
//
//   state  | meaning
//   ST_GAP | led off, counting four gap phases before the next burst
//   ST_ON  | led on for one phase of a blink
//   ST_OFF | led off for one phase between blinks
module led_heartbeat_gen #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 24,
    parameter int TICK_DIV = 125000,
    parameter int HP_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    led_heartbeat_gen_if.slave bus
);
    localparam int             PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_GAP = 2'd0,
        ST_ON  = 2'd1,
        ST_OFF = 2'd2
    } code_st_e;

    logic [PRE_W-1:0]    pre_cnt;
    logic [HP_W-1:0]     ph_cnt;
    logic [HP_W-1:0]     hp_m1;
    logic                tick;
    logic                phase;
    logic                phase_r;
    logic [3*NUM_CH-1:0] mode_r;
    logic [NUM_CH-1:0]   led_nxt;
    logic [NUM_CH-1:0]   led_r;

    // A half-period of 0 behaves exactly like 1.
    assign hp_m1 = (bus.half_period_i == '0) ? '0 : bus.half_period_i - HP_W'(1);
    assign tick  = (pre_cnt == PRE_LAST);
    assign phase = tick && (ph_cnt == hp_m1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            ph_cnt  <= '0;
            phase_r <= 1'b0;
            mode_r  <= '0;
            led_r   <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick) begin
                ph_cnt <= phase ? '0 : ph_cnt + HP_W'(1);
            end
            phase_r <= phase;
            mode_r  <= bus.mode_i;
            led_r   <= led_nxt;
        end
    end

    assign bus.led_o   = led_r;
    assign bus.phase_o = phase_r;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [2:0]       mode_now;
        logic [2:0]       mode_reg;
        logic [3:0]       code_now;
        logic             chg;
        logic             toggle_q, toggle_d;
        code_st_e         st_q, st_d;
        logic [1:0]       gap_q, gap_d;
        logic [3:0]       blink_q, blink_d;
        logic [3:0]       code_q, code_d;
        logic [CNT_W-1:0] frc_q, frc_d;
        logic             led_d;

        assign mode_now = bus.mode_i[3*k +: 3];
        assign mode_reg = mode_r[3*k +: 3];
        assign code_now = bus.code_i[4*k +: 4];
        assign chg      = (mode_now != mode_reg);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                toggle_q <= 1'b0;
                st_q     <= ST_GAP;
                gap_q    <= '0;
                blink_q  <= '0;
                code_q   <= '0;
                frc_q    <= '0;
            end else begin
                toggle_q <= toggle_d;
                st_q     <= st_d;
                gap_q    <= gap_d;
                blink_q  <= blink_d;
                code_q   <= code_d;
                frc_q    <= frc_d;
            end
        end

        // A mode change re-initialises the channel and swallows a coincident phase.
        always_comb begin
            toggle_d = toggle_q;
            st_d     = st_q;
            gap_d    = gap_q;
            blink_d  = blink_q;
            code_d   = code_q;
            frc_d    = frc_q + CNT_W'(1);
            led_d    = 1'b0;
            if (chg) begin
                toggle_d = 1'b0;
                st_d     = ST_GAP;
                gap_d    = '0;
                blink_d  = '0;
                frc_d    = '0;
            end else begin
                if (phase) begin
                    toggle_d = ~toggle_q;
                end
                if (phase && (mode_reg == 3'd3)) begin
                    unique case (st_q)
                        ST_GAP: begin
                            if (gap_q == 2'd3) begin
                                code_d = code_now;
                                gap_d  = '0;
                                if (code_now != 4'd0) begin
                                    st_d    = ST_ON;
                                    blink_d = 4'd1;
                                end
                            end else begin
                                gap_d = gap_q + 2'd1;
                            end
                        end
                        ST_ON: st_d = ST_OFF;
                        ST_OFF: begin
                            if (blink_q == code_q) begin
                                st_d  = ST_GAP;
                                gap_d = '0;
                            end else begin
                                st_d    = ST_ON;
                                blink_d = blink_q + 4'd1;
                            end
                        end
                        default: st_d = ST_GAP;
                    endcase
                end
            end
            // Decode from next state so phase-driven edges line up with phase_o.
            case (mode_reg)
                3'd1:    led_d = 1'b1;
                3'd2:    led_d = toggle_d;
                3'd3:    led_d = (st_d == ST_ON);
                3'd4:    led_d = frc_d[CNT_W-1];
                default: led_d = 1'b0;
            endcase
        end

        assign led_nxt[k] = led_d;
    end
endmodule
